// File: rtl/flag_branch_unit_pkg.sv
// Shared encodings for the ALU flag / branch resolution path.
package flag_branch_unit_pkg;

  // ALU opcodes as seen on the EX stage
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_RED    = 3'b010;
  localparam logic [2:0] OP_XOR    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  // Branch condition codes
  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  // Bit positions inside {N,Z,V}
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {ST_IDLE, ST_HOLD} br_state_e;

  // True for ops that write at least one flag (RED/PADDSB leave flags alone)
  function automatic logic op_sets_flags(input logic [2:0] op);
    case (op)
      OP_RED, OP_PADDSB: return 1'b0;
      default:           return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/flag_branch_unit_br_cond_eval.sv
// Pure combinational condition-code evaluator over {N,Z,V}.
module br_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic w_n, w_z, w_v;
  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_v = flags[FLAG_V];

  // Decode the condition against the supplied flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:   taken = ~w_z;
      CC_EQ:   taken = w_z;
      CC_GT:   taken = ~w_z & ~w_n;
      CC_LT:   taken = w_n;
      CC_GE:   taken = w_z | (~w_z & ~w_n);
      CC_LE:   taken = w_n | w_z;
      CC_OV:   taken = w_v;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register plus conditional-branch resolver with hazard stall.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int         FWD         = 0,
  parameter logic [2:0] RESET_FLAGS = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_flush,
  input  logic [2:0]  ex_op,
  input  logic [2:0]  alu_flag,
  input  logic [15:0] alu_out,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  output logic        br_ready,
  output logic        br_done,
  output logic        br_taken,
  output logic [2:0]  flag_q,
  output logic        stall
);

  localparam logic USE_FWD = (FWD != 0);

  br_state_e   r_state, w_state_nxt;
  logic [2:0]  r_flag_q, w_flag_nxt, w_eff;
  logic [2:0]  r_cond;
  logic        r_done, r_taken;
  logic        w_flag_set, w_ex_live;
  logic        w_ready, w_stall, w_capture, w_taken;
  logic [2:0]  w_eval_cond, w_eval_flags;

  assign w_ex_live  = ex_valid & ~ex_flush;
  assign w_flag_set = w_ex_live & op_sets_flags(ex_op);

  // Value the flag register takes at this edge
  always_comb begin
    w_flag_nxt = r_flag_q;
    if (w_ex_live) begin
      case (ex_op)
        OP_ADD, OP_SUB:                 w_flag_nxt = alu_flag;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_flag_nxt[FLAG_Z] = (alu_out == 16'h0000);
        default:                        w_flag_nxt = r_flag_q;
      endcase
    end
  end

  // Bypass the in-flight update only when forwarding is built in
  assign w_eff = (USE_FWD && w_flag_set) ? w_flag_nxt : r_flag_q;

  // Branch FSM: accept, or stall one cycle behind a flag writer
  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b0;
    w_stall      = 1'b0;
    w_capture    = 1'b0;
    w_eval_cond  = br_cond;
    w_eval_flags = w_eff;
    case (r_state)
      ST_IDLE: begin
        if (br_valid) begin
          if (!USE_FWD && w_flag_set) begin
            w_stall     = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_ready = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Flags are settled; a flag write this cycle lands after the branch
        w_ready      = 1'b1;
        w_eval_cond  = r_cond;
        w_eval_flags = r_flag_q;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  br_cond_eval u_eval (
    .cond  (w_eval_cond),
    .flags (w_eval_flags),
    .taken (w_taken)
  );

  // State, captured condition, resolution pulse and flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cond   <= 3'b000;
      r_done   <= 1'b0;
      r_taken  <= 1'b0;
      r_flag_q <= RESET_FLAGS;
    end else begin
      r_state  <= w_state_nxt;
      r_done   <= w_ready;
      r_flag_q <= w_flag_nxt;
      if (w_capture) r_cond  <= br_cond;
      if (w_ready)   r_taken <= w_taken;
    end
  end

  assign br_ready = w_ready;
  assign br_done  = r_done;
  assign br_taken = r_taken;
  assign flag_q   = r_flag_q;
  assign stall    = w_stall;

endmodule
